alu_acc_ctrl: RTL and testbench
===============================

// Module: alu_acc_ctrl
// PURPOSE
//  Accumulator/sequencer stage wrapped around the combinational 8-bit ALU (alub).
//  Accepts commands over a valid/ready interface, drives the ALU A/B/ALU_Sel
//  inputs with A = accumulator, then captures Result into the accumulator and
//  NZVC into the flag register. Returns each outcome on a valid/ready response port.
// PARAMETERS
//  WIDTH     8   datapath width; must match the ALU instance
//  CNT_W     16  width of the executed-operation counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       controller can accept a command
//  cmd_load     in   1       1 = load cmd_operand into acc directly; no ALU op
//  cmd_op       in   3       ALU_Sel: 0 ADD,1 INC,2 SUB,3 DEC,4 AND,5 OR,6 XOR,7 NOT
//  cmd_operand  in   WIDTH   B operand, or load value
//  alu_a        out  WIDTH   to ALU A
//  alu_b        out  WIDTH   to ALU B
//  alu_sel      out  3       to ALU ALU_Sel
//  alu_result   in   WIDTH   from ALU Result
//  alu_nzvc     in   4       from ALU NZVC: [3]N [2]Z [1]V [0]C
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer accepts response
//  rsp_acc      out  WIDTH   accumulator after the command
//  rsp_nzvc     out  4       flag register after the command
//  v_sticky     out  1       set when any ALU op returns V=1
//  v_clr        in   1       synchronous clear of v_sticky
//  op_count     out  CNT_W   count of completed ALU ops (loads excluded); wraps
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; acc, alu_a, alu_b, alu_sel, rsp_acc = 0;
//   flags, rsp_nzvc = 0; rsp_valid=0; v_sticky=0; op_count=0.
//   cmd_ready = 0 while rst_n=0. Reset mid-operation discards the in-flight
//   command; no response is issued.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready=1. Handshake when cmd_valid & cmd_ready. Register
//    alu_b=cmd_operand, alu_sel=cmd_op, load flag. alu_a tracks acc at all times.
//    Next state: EXEC.
//   EXEC: cmd_ready=0; the ALU settles combinationally.
//    Load: acc<=operand, flags unchanged.
//    Otherwise: acc<=alu_result, flags<=alu_nzvc, op_count<=op_count+1 (mod 2^CNT_W),
//    and v_sticky<=1 if alu_nzvc[1].
//    Then rsp_acc/rsp_nzvc <= the new values, rsp_valid<=1. Next state: RESP.
//   RESP: hold rsp_* stable while rsp_valid & !rsp_ready. On rsp_ready: rsp_valid<=0.
//    Next state: IDLE.
//  Latency: accept at edge N; rsp_valid=1 after edge N+1. Minimum issue interval is
//   3 cycles with rsp_ready tied high.
//  Back-to-back commands: the following command is not accepted until IDLE is re-entered.
//   cmd_ready is a registered function of state only.
//  v_clr and a set in the same cycle: set wins.
//  Arithmetic: no arithmetic in this block beyond op_count. Wrap-around and flag
//   semantics are those of the ALU. The ALU outputs are treated as combinational
//   and are sampled only in EXEC.
//  alu_b/alu_sel keep their last values outside EXEC.
// TESTING
//  1 load 100, ADD 30 -> rsp_acc=0x82, N=1,V=1, v_sticky=1, op_count=1
//  2 load 127, INC -> rsp_acc=0x80, N=1,V=1; then DEC -> rsp_acc=0x7F, V=1
//  3 load 78, AND 121 -> rsp_acc=0x48, N=0,Z=0; then XOR 0x48 -> rsp_acc=0, Z=1
//  4 rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, second cmd not taken
//  5 assert rst_n=0 during EXEC -> all outputs 0, no rsp; next cmd accepted normally
//  6 preload op_count near 2^CNT_W-1 via 2^CNT_W ops (or reduced CNT_W=4) -> wraps to 0;
//    v_clr with a concurrent V=1 op -> v_sticky stays 1

Source files
------------

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: accumulator/sequencer wrapped around an external combinational ALU.
// Commands enter over cmd_valid/cmd_ready, the ALU is driven with A = accumulator,
// and the settled Result/NZVC are captured in EXEC. Each outcome is returned on
// the rsp_valid/rsp_ready port.
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid & ready are both 1; a producer holds its payload stable while valid & !ready.
module alu_acc_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_nzvc,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_acc,
   output logic [3:0]       rsp_nzvc,
   output logic             v_sticky,
   input  logic             v_clr,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_exec;
   logic             w_rsp_done;

   logic             r_cmd_ready;
   logic             r_load;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_sel;
   logic [3:0]       r_flags;
   logic [WIDTH-1:0] r_rsp_acc;
   logic [3:0]       r_rsp_nzvc;
   logic             r_rsp_valid;
   logic             r_v_sticky;
   logic [CNT_W-1:0] r_op_count;
   logic             w_alu_op;
   logic             w_v_set;

   // Next-state decode and per-state strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = cmd_valid & r_cmd_ready;
            if (w_accept) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_exec      = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_rsp_done = rsp_ready;
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; cmd_ready is registered from the next state only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= (w_state_nxt == S_IDLE);
      end
   end

   // Capture the accepted command; ALU B/Sel hold their last values otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_b   <= '0;
         r_alu_sel <= 3'd0;
         r_load    <= 1'b0;
      end else if (w_accept) begin
         r_alu_b   <= cmd_operand;
         r_alu_sel <= cmd_op;
         r_load    <= cmd_load;
      end
   end

   assign w_alu_op = w_exec & ~r_load;
   assign w_v_set  = w_alu_op & alu_nzvc[1];

   // EXEC: commit accumulator/flags and publish the response payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_flags    <= 4'd0;
         r_rsp_acc  <= '0;
         r_rsp_nzvc <= 4'd0;
      end else if (w_exec) begin
         if (r_load) begin
            r_acc      <= r_alu_b;
            r_rsp_acc  <= r_alu_b;
            r_rsp_nzvc <= r_flags;
         end else begin
            r_acc      <= alu_result;
            r_flags    <= alu_nzvc;
            r_rsp_acc  <= alu_result;
            r_rsp_nzvc <= alu_nzvc;
         end
      end
   end

   // Count completed ALU operations (loads do not count); wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_op_count <= '0;
      else if (w_alu_op) r_op_count <= r_op_count + CNT_W'(1);
   end

   // Response valid: raised by EXEC, dropped when the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rsp_valid <= 1'b0;
      else if (w_exec) r_rsp_valid <= 1'b1;
      else if (w_rsp_done) r_rsp_valid <= 1'b0;
   end

   // Sticky overflow: a set in the same cycle as v_clr takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_v_sticky <= 1'b0;
      else if (w_v_set) r_v_sticky <= 1'b1;
      else if (v_clr) r_v_sticky <= 1'b0;
   end

   assign cmd_ready = r_cmd_ready;
   assign alu_a     = r_acc;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_acc   = r_rsp_acc;
   assign rsp_nzvc  = r_rsp_nzvc;
   assign v_sticky  = r_v_sticky;
   assign op_count  = r_op_count;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: behavioural 8-bit ALU on the ALU ports, a reference
// model of the accumulator/flags/sticky/counter, and an expected-response queue.
module tb_alu_acc_ctrl;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_load = 1'b0;
   logic [2:0]    cmd_op = 3'd0;
   logic [W-1:0]  cmd_operand = '0;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [2:0]    alu_sel;
   logic [3:0]    alu_nzvc;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_acc;
   logic [3:0]    rsp_nzvc;
   logic          v_sticky;
   logic          v_clr = 1'b0;
   logic [CW-1:0] op_count;
   logic [1:0]    dbg_state;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0]  m_acc = 8'd0;
   logic [3:0]  m_flags = 4'd0;
   logic        m_vs = 1'b0;
   logic [3:0]  m_cnt = 4'd0;
   logic [16:0] exp_q[$];
   logic [7:0]  last_acc;
   logic [3:0]  last_nzvc;

   alu_acc_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_nzvc(alu_nzvc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_acc(rsp_acc), .rsp_nzvc(rsp_nzvc),
      .v_sticky(v_sticky), .v_clr(v_clr), .op_count(op_count),
      .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ALU behaviour: returns {N,Z,V,C, result}
   function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
      int ai, bi, s;
      logic [7:0] r;
      logic v, c;
      ai = int'(a);
      bi = int'(b);
      v = 1'b0;
      c = 1'b0;
      r = 8'd0;
      case (sel)
         3'd0, 3'd1: begin
            if (sel == 3'd1) bi = 1;
            s = ai + bi;
            r = 8'(s);
            c = (s > 255);
            v = ($signed(a) + $signed(8'(bi)) > 127) || ($signed(a) + $signed(8'(bi)) < -128);
         end
         3'd2, 3'd3: begin
            if (sel == 3'd3) bi = 1;
            s = ai - bi;
            r = 8'(s);
            c = (ai < bi);
            v = ($signed(a) - $signed(8'(bi)) > 127) || ($signed(a) - $signed(8'(bi)) < -128);
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
      return {r[7], (r == 8'd0), v, c, r};
   endfunction

   always_comb {alu_nzvc, alu_result} = alu_f(alu_a, alu_b, alu_sel);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 8'd0;
      m_flags = 4'd0;
      m_vs = 1'b0;
      m_cnt = 4'd0;
      exp_q.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_acc",   32'(rsp_acc), 32'd0);
      chk("rst_rsp_nzvc",  32'(rsp_nzvc), 32'd0);
      chk("rst_alu_a",     32'(alu_a), 32'd0);
      chk("rst_alu_b",     32'(alu_b), 32'd0);
      chk("rst_alu_sel",   32'(alu_sel), 32'd0);
      chk("rst_v_sticky",  32'(v_sticky), 32'd0);
      chk("rst_op_count",  32'(op_count), 32'd0);
      model_reset();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      v_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One command: issue, EXEC checks, response checks, optional back-pressure
   task automatic send(input logic ld, input logic [2:0] op, input logic [7:0] opnd,
                       input int hold, input logic vclr);
      int t;
      logic [7:0]  r;
      logic [3:0]  f;
      logic [16:0] e;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_ready_wait", 32'(t < 10), 32'd1);
      if (ld) begin
         m_acc = opnd;
         if (vclr) m_vs = 1'b0;
      end else begin
         {f, r} = alu_f(m_acc, opnd, op);
         m_acc = r;
         m_flags = f;
         m_cnt = m_cnt + 4'd1;
         if (f[1]) m_vs = 1'b1;
         else if (vclr) m_vs = 1'b0;
      end
      exp_q.push_back({m_vs, m_cnt, m_flags, m_acc});
      cmd_valid = 1'b1;
      cmd_load = ld;
      cmd_op = op;
      cmd_operand = opnd;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_operand = 8'($urandom);
      cmd_op = 3'($urandom);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_b", 32'(alu_b), 32'(opnd));
      chk("exec_alu_sel", 32'(alu_sel), 32'(op));
      v_clr = vclr;
      @(negedge clk);
      v_clr = 1'b0;
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
      e = exp_q.pop_front();
      chk("rsp_acc", 32'(rsp_acc), 32'(e[7:0]));
      chk("rsp_nzvc", 32'(rsp_nzvc), 32'(e[11:8]));
      chk("op_count", 32'(op_count), 32'(e[15:12]));
      chk("v_sticky", 32'(v_sticky), 32'(e[16]));
      chk("alu_a_tracks", 32'(alu_a), 32'(e[7:0]));
      last_acc = rsp_acc;
      last_nzvc = rsp_nzvc;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_load = 1'b0;
         cmd_operand = ~opnd;
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_acc", 32'(rsp_acc), 32'(e[7:0]));
         chk("hold_rsp_nzvc", 32'(rsp_nzvc), 32'(e[11:8]));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_alu_b", 32'(alu_b), 32'(opnd));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      apply_reset();

      // directed: load 100, ADD 30
      send(1'b1, 3'd0, 8'd100, 0, 1'b0);
      chk("t1_load_acc", 32'(last_acc), 32'd100);
      send(1'b0, 3'd0, 8'd30, 0, 1'b0);
      chk("t1_acc", 32'(last_acc), 32'h82);
      chk("t1_n", 32'(last_nzvc[3]), 32'd1);
      chk("t1_v", 32'(last_nzvc[1]), 32'd1);
      chk("t1_sticky", 32'(v_sticky), 32'd1);
      chk("t1_count", 32'(op_count), 32'd1);

      // directed: load 127, INC, DEC
      send(1'b1, 3'd0, 8'd127, 0, 1'b0);
      send(1'b0, 3'd1, 8'd0, 0, 1'b0);
      chk("t2_inc_acc", 32'(last_acc), 32'h80);
      chk("t2_inc_nv", 32'({last_nzvc[3], last_nzvc[1]}), 32'd3);
      send(1'b0, 3'd3, 8'd0, 0, 1'b0);
      chk("t2_dec_acc", 32'(last_acc), 32'h7F);
      chk("t2_dec_v", 32'(last_nzvc[1]), 32'd1);

      // directed: load 78, AND 121, XOR 0x48
      send(1'b1, 3'd0, 8'd78, 0, 1'b0);
      send(1'b0, 3'd4, 8'd121, 0, 1'b0);
      chk("t3_and_acc", 32'(last_acc), 32'h48);
      chk("t3_and_nz", 32'({last_nzvc[3], last_nzvc[2]}), 32'd0);
      send(1'b0, 3'd6, 8'h48, 0, 1'b0);
      chk("t3_xor_acc", 32'(last_acc), 32'h00);
      chk("t3_xor_z", 32'(last_nzvc[2]), 32'd1);

      // back-pressure: response held 5 cycles with a stray command pending
      send(1'b0, 3'd5, 8'h81, 5, 1'b0);

      // reset during EXEC
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_load = 1'b0;
      cmd_op = 3'd0;
      cmd_operand = 8'd55;
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("midrst_acc", 32'(alu_a), 32'd0);
      chk("midrst_rsp_acc", 32'(rsp_acc), 32'd0);
      chk("midrst_count", 32'(op_count), 32'd0);
      chk("midrst_sticky", 32'(v_sticky), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      send(1'b0, 3'd0, 8'd9, 0, 1'b0);
      chk("midrst_next_acc", 32'(last_acc), 32'd9);

      // counter wrap (CNT_W=4): 15 more ops reach 0
      for (int i = 0; i < 14; i++) send(1'b0, 3'd1, 8'd0, 0, 1'b0);
      chk("cnt_15", 32'(op_count), 32'd15);
      send(1'b1, 3'd0, 8'd127, 0, 1'b0);
      // v_clr in the same cycle as an overflowing INC: set wins
      send(1'b0, 3'd1, 8'd0, 0, 1'b1);
      chk("cnt_wrap", 32'(op_count), 32'd0);
      chk("set_beats_clr", 32'(v_sticky), 32'd1);
      // v_clr with a non-overflowing op clears
      send(1'b0, 3'd4, 8'hFF, 0, 1'b1);
      chk("clr_sticky", 32'(v_sticky), 32'd0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            v_clr = 1'b1;
            @(negedge clk);
            v_clr = 1'b0;
            m_vs = 1'b0;
            chk("idle_vclr", 32'(v_sticky), 32'd0);
         end
         send(($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              ($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
